// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start and the operands; the subtractor drives the result and status.
interface serial_subtractor_if #(
    parameter int width = 3
);
    logic             start;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             bin;
    logic [width-1:0] d;
    logic             bout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, bin,
        input  d, bout, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output d, bout, busy, done
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell computes a - b - bin LSB first,
// one bit per clock, with a start/done handshake and registered result.
module serial_subtractor #(
    parameter int width = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (width > 1) ? $clog2(width) : 1;

    if (width < 1) begin : g_width_check
        $error("serial_subtractor: width must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [width-1:0] a_sr;
    logic [width-1:0] b_sr;
    logic [width-1:0] res_sr;
    logic [width-1:0] res_shift;
    logic [width-1:0] d_q;
    logic             bout_q;
    logic             brw;
    logic             brw_next;
    logic             diff;
    logic             accept;
    logic             last_bit;
    logic [CW-1:0]    cnt;

    // A start is honoured only when idle or in the completion cycle.
    always_comb begin
        accept   = bus.start && ((state == IDLE) || (state == DONE));
        last_bit = (state == RUN) && (cnt == CW'(width - 1));
    end

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        diff      = a_sr[0] ^ b_sr[0] ^ brw;
        brw_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
        res_shift = res_sr >> 1;
        res_shift[width-1] = diff;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
        bus.d    = d_q;
        bus.bout = bout_q;
    end

    // Result register only updates on the final bit, so d/bout hold across RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            brw    <= brw_next;
            res_sr <= res_shift;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                d_q    <= res_shift;
                bout_q <= brw_next;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at widths 3, 1 and 4.
// Drivers queue expected results; per-instance monitors check them on each done pulse.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.width(3)) if3 ();
    serial_subtractor_if #(.width(1)) if1 ();
    serial_subtractor_if #(.width(4)) if4 ();

    serial_subtractor #(.width(3)) u3 (.clk(clk), .reset_n(reset_n), .bus(if3));
    serial_subtractor #(.width(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    serial_subtractor #(.width(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(if4));

    typedef struct {
        int a;
        int b;
        int bin;
        int exp;
    } txn_t;

    txn_t q3[$];
    txn_t q1[$];
    txn_t q4[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: {bout, d} is simply the difference taken modulo 2^(w+1).
    function automatic txn_t mk(input int a, input int b, input int bin, input int w);
        txn_t t;
        t.a   = a;
        t.b   = b;
        t.bin = bin;
        t.exp = (a - b - bin) & ((1 << (w + 1)) - 1);
        return t;
    endfunction

    task automatic judge(input string tag, input int w, input int dv, input int bv, input txn_t t);
        int mask;
        mask = (1 << w) - 1;
        check({tag, " d"}, dv, t.exp & mask);
        check({tag, " bout"}, bv, t.exp >> w);
        check({tag, " d+b+bin==a"}, (dv + t.b + t.bin) & mask, t.a);
    endtask

    // Monitors: score each done, and require outputs to hold between completions.
    int last3 = 0, last1 = 0, last4 = 0;
    int pd3 = 0, pd1 = 0, pd4 = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            last3 = 0;
            pd3   = 0;
        end else begin
            if (if3.done) begin
                check("w3 done single-cycle", pd3, 0);
                if (q3.size() == 0) check("w3 unexpected done", 1, 0);
                else judge("w3", 3, int'(if3.d), int'(if3.bout), q3.pop_front());
                last3 = int'({if3.bout, if3.d});
            end else begin
                check("w3 result hold", int'({if3.bout, if3.d}), last3);
            end
            pd3 = int'(if3.done);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            last1 = 0;
            pd1   = 0;
        end else begin
            if (if1.done) begin
                check("w1 done single-cycle", pd1, 0);
                if (q1.size() == 0) check("w1 unexpected done", 1, 0);
                else judge("w1", 1, int'(if1.d), int'(if1.bout), q1.pop_front());
                last1 = int'({if1.bout, if1.d});
            end else begin
                check("w1 result hold", int'({if1.bout, if1.d}), last1);
            end
            pd1 = int'(if1.done);
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            last4 = 0;
            pd4   = 0;
        end else begin
            if (if4.done) begin
                check("w4 done single-cycle", pd4, 0);
                if (q4.size() == 0) check("w4 unexpected done", 1, 0);
                else judge("w4", 4, int'(if4.d), int'(if4.bout), q4.pop_front());
                last4 = int'({if4.bout, if4.d});
            end else begin
                check("w4 result hold", int'({if4.bout, if4.d}), last4);
            end
            pd4 = int'(if4.done);
        end
    end

    // Drivers: each go* assumes the DUT is idle or in its done cycle.
    task automatic go3(input int a, input int b, input int bin, input bit push);
        if3.a     = a[2:0];
        if3.b     = b[2:0];
        if3.bin   = bin[0];
        if3.start = 1'b1;
        if (push) q3.push_back(mk(a, b, bin, 3));
        @(posedge clk); #1;
        if3.start = 1'b0;
    endtask

    task automatic go1(input int a, input int b, input int bin);
        if1.a     = a[0:0];
        if1.b     = b[0:0];
        if1.bin   = bin[0];
        if1.start = 1'b1;
        q1.push_back(mk(a, b, bin, 1));
        @(posedge clk); #1;
        if1.start = 1'b0;
    endtask

    task automatic go4(input int a, input int b, input int bin);
        if4.a     = a[3:0];
        if4.b     = b[3:0];
        if4.bin   = bin[0];
        if4.start = 1'b1;
        q4.push_back(mk(a, b, bin, 4));
        @(posedge clk); #1;
        if4.start = 1'b0;
    endtask

    task automatic wait_done3();
        int n = 0;
        while (!if3.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w3 done within bound", int'(if3.done), 1);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!if1.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w1 done within bound", int'(if1.done), 1);
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!if4.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("w4 done within bound", int'(if4.done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    int ca[4]   = '{3, 0, 7, 7};
    int cb[4]   = '{5, 0, 7, 0};
    int cbin[4] = '{0, 1, 1, 0};

    initial begin
        if3.start = 1'b0; if3.a = '0; if3.b = '0; if3.bin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;

        #1 reset_n = 1'b0;
        #2;
        check("reset d", int'(if3.d), 0);
        check("reset bout", int'(if3.bout), 0);
        check("reset busy", int'(if3.busy), 0);
        check("reset done", int'(if3.done), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Basic case with exact cycle timing of busy and done.
        go3(5, 3, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("basic busy during run", int'(if3.busy), 1);
            check("basic no early done", int'(if3.done), 0);
            @(posedge clk); #1;
        end
        check("basic done at k+3", int'(if3.done), 1);
        check("basic busy low in done", int'(if3.busy), 0);
        @(posedge clk); #1;
        check("basic done one cycle", int'(if3.done), 0);
        check("basic idle busy", int'(if3.busy), 0);

        for (int i = 0; i < 4; i++) begin
            go3(ca[i], cb[i], cbin[i], 1'b1);
            wait_done3();
            @(posedge clk); #1;
        end

        // A start raised mid-run must be neither taken nor remembered.
        go3(6, 3, 0, 1'b1);
        @(posedge clk); #1;
        if3.a = 3'd1; if3.b = 3'd1; if3.start = 1'b1;
        @(posedge clk); #1;
        if3.start = 1'b0;
        wait_done3();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("ignored start no second done", int'(if3.done), 0);
            check("ignored start stays idle", int'(if3.busy), 0);
        end

        // Back-to-back with start held high across the done cycle.
        if3.a = 3'd6; if3.b = 3'd2; if3.bin = 1'b0; if3.start = 1'b1;
        q3.push_back(mk(6, 2, 0, 3));
        @(posedge clk); #1;
        if3.a = 3'd2; if3.b = 3'd6; if3.bin = 1'b0;
        wait_done3();
        q3.push_back(mk(2, 6, 0, 3));
        @(posedge clk); #1;
        check("b2b no idle gap", int'(if3.busy), 1);
        if3.start = 1'b0;
        wait_done3();
        @(posedge clk); #1;

        // Asynchronous reset during the second RUN cycle.
        go3(5, 2, 0, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        q3.delete();
        #1;
        check("async reset d", int'(if3.d), 0);
        check("async reset bout", int'(if3.bout), 0);
        check("async reset busy", int'(if3.busy), 0);
        check("async reset done", int'(if3.done), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post-reset no done", int'(if3.done), 0);
        end
        go3(4, 1, 1, 1'b1);
        wait_done3();
        @(posedge clk); #1;

        // Random operations, sometimes chained on the done cycle.
        for (int i = 0; i < 40; i++) begin
            go3(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 1)), 1'b1);
            wait_done3();
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        @(posedge clk); #1;

        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 2; c++) begin
                    go1(a, b, c);
                    wait_done1();
                    @(posedge clk); #1;
                end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    go4(a, b, c);
                    wait_done4();
                    @(posedge clk); #1;
                end

        repeat (5) @(posedge clk);
        #1;
        check("w3 scoreboard drained", q3.size(), 0);
        check("w1 scoreboard drained", q1.size(), 0);
        check("w4 scoreboard drained", q4.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor with start/done handshake; computes a - b - bin one bit per clock, LSB first.
- It is the inverse-operation companion to the team's parameterised ripple-carry adder.
- Trades latency for a single full-subtractor cell.
- Used where area matters more than throughput; results are self-checkable against the adder (d + b + bin == a, modulo 2^width).

Parameters:
- width, 3, operand and result width in bits; legal range >= 1.

Ports:
- clk      input   1      rising-edge clock
- reset_n  input   1      asynchronous, active-low reset
- start    input   1      request; sampled on rising clk only when the block is idle or done
- a        input   width  minuend; captured on the accepted-start edge
- b        input   width  subtrahend; captured on the accepted-start edge
- bin      input   1      borrow-in; captured on the accepted-start edge
- d        output  width  difference register
- bout     output  1      borrow-out register
- busy     output  1      high while a subtraction is in progress
- done     output  1      single-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- Reset (reset_n low, asynchronous): state=IDLE; d=0, bout=0, busy=0, done=0; shift registers and bit counter cleared.
- Reset mid-operation aborts the operation with no done pulse. After release, the block waits in IDLE for a new start.
- States: IDLE, RUN, DONE.
  - IDLE, start=1 at edge: capture a, b, bin into shift registers and borrow flop; bit counter=0; next state RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, each edge: process one bit.
    - diff = a0 ^ b0 ^ brw
    - brw_next = (~a0 & b0) | (~(a0 ^ b0) & brw)
    - diff shifts into the result shift register from the MSB side; operand registers shift right; counter increments.
  - RUN, edge processing bit width-1: load d with the complete result and bout with the final borrow; next state DONE.
  - DONE, lasts exactly one cycle: done=1.
    - start=1 at this edge is accepted: capture operands, go to RUN. Back-to-back operations are supported with no idle gap.
    - Otherwise go to IDLE.
- busy = 1 exactly while state == RUN.
- done = 1 exactly while state == DONE.
- Timing: with the start-accepting edge at k, busy is high after edges k .. k+width-1, and done is high for the single cycle after edge k+width. Latency is width edges from acceptance to done.
- start while RUN is ignored and never queued. Operand changes during RUN have no effect.
- d and bout change only on the edge entering DONE. They hold the previous result throughout RUN, IDLE and DONE, and are valid from the done cycle until the next completion.
- Arithmetic:
  - d = (a - b - bin) mod 2^width, unsigned.
  - bout = 1 iff a < b + bin, evaluated as unsigned with no overflow.
  - Equivalently, {bout, d} == (a - b - bin) mod 2^(width+1).
- Counter width is max(1, clog2(width)). width=1 must work: one RUN cycle, then DONE.

Test Plan (width=3 unless noted; each case: pulse start 1 cycle, wait for done, check d/bout in done cycle):
- Basic: a=5, b=3, bin=0 -> d=2, bout=0; done exactly 3 edges after the accepting edge; busy high for 3 cycles; done high for 1 cycle.
- Borrow and wrap:
  - a=3, b=5, bin=0 -> d=6, bout=1
  - a=0, b=0, bin=1 -> d=7, bout=1
  - a=7, b=7, bin=1 -> d=7, bout=1
  - a=7, b=0, bin=0 -> d=7, bout=0
- Ignored start and stable outputs: assert start again with a=1, b=1 two cycles into a 6-3 operation -> result d=3, bout=0. Then a single done, no second operation, and d/bout unchanged during RUN of the next operation until its done.
- Back-to-back: hold start=1 with operand pairs (6,2,0) then (2,6,0) -> first done: d=4, bout=0. Second operation is accepted on the done edge; its done follows 3 edges later with d=4, bout=1. No IDLE cycle between the two operations.
- Reset mid-run: assert reset_n=0 asynchronously during the second RUN cycle -> d, bout, busy, done go to 0 immediately with no clock. No done follows. A fresh start after release gives the correct result (4-1-1 -> d=2, bout=0).
- Exhaustive sweep (width=1 and width=4): all a, b, bin combinations -> {bout, d} === (a - b - bin) mod 2^(width+1). Also check d + b + bin mod 2^width == a.
